// File: rtl/stream_sweep_controller.sv
// D2Q9 streaming-pass sequencer: walks every lattice node in raster order, reads its nine
// distributions from the source lattice and scatters them to the streaming_unit destinations.
module stream_sweep_controller #(
  parameter int GRID_X        = 16,
  parameter int GRID_Y        = 16,
  parameter int GRID_DIM      = GRID_X * GRID_Y,
  parameter int ADDRESS_WIDTH = $clog2(GRID_DIM) + 1,
  parameter int NODE_AW       = $clog2(GRID_DIM),
  parameter int DATA_WIDTH    = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic signed [ADDRESS_WIDTH-1:0] x,
  output logic signed [ADDRESS_WIDTH-1:0] y,
  input  logic [9*ADDRESS_WIDTH-1:0]      write_addresses,
  output logic                            rd_en,
  output logic [NODE_AW-1:0]              rd_addr,
  input  logic [9*DATA_WIDTH-1:0]         rd_data,
  output logic                            wr_en,
  input  logic                            wr_ready,
  output logic [3:0]                      wr_dir,
  output logic [NODE_AW-1:0]              wr_addr,
  output logic [DATA_WIDTH-1:0]           wr_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic signed [ADDRESS_WIDTH-1:0] X_LAST     = ADDRESS_WIDTH'(GRID_X - 1);
  localparam logic signed [ADDRESS_WIDTH-1:0] Y_LAST     = ADDRESS_WIDTH'(GRID_Y - 1);
  localparam logic signed [ADDRESS_WIDTH-1:0] COORD_ZERO = {ADDRESS_WIDTH{1'b0}};
  localparam logic signed [ADDRESS_WIDTH-1:0] COORD_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NODE_AW-1:0]              NODE_ZERO  = {NODE_AW{1'b0}};
  localparam logic [NODE_AW-1:0]              NODE_ONE   = {{(NODE_AW-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0]           DATA_ZERO  = {DATA_WIDTH{1'b0}};

  state_t                            state_r, state_next_s;
  logic signed [ADDRESS_WIDTH-1:0]   x_r, y_r, x_next_s, y_next_s;
  logic [NODE_AW-1:0]                node_r, node_next_s;
  logic [3:0]                        dir_r, dir_next_s;
  logic [DATA_WIDTH-1:0]             data_buf_r [9];
  logic [NODE_AW-1:0]                addr_buf_r [9];
  logic [DATA_WIDTH-1:0]             data_slice_s [9];
  logic [NODE_AW-1:0]                addr_slice_s [9];
  logic [8:0]                        addr_hi_unused_s;
  logic                              busy_next_s, done_next_s, rd_en_next_s, wr_en_next_s;
  logic [NODE_AW-1:0]                rd_addr_next_s, wr_addr_next_s;
  logic [3:0]                        wr_dir_next_s;
  logic [DATA_WIDTH-1:0]             wr_data_next_s;

  // Split the packed per-direction buses; address slices beyond NODE_AW are deliberately ignored.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      data_slice_s[i]     = rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      addr_slice_s[i]     = write_addresses[i*ADDRESS_WIDTH +: NODE_AW];
      addr_hi_unused_s[i] = ^write_addresses[i*ADDRESS_WIDTH+NODE_AW +: ADDRESS_WIDTH-NODE_AW];
    end
  end

  // Next-state, node/direction counters and the next value of every registered output.
  always_comb begin
    state_next_s = state_r;
    x_next_s     = x_r;
    y_next_s     = y_r;
    node_next_s  = node_r;
    dir_next_s   = dir_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_next_s = S_READ;
          x_next_s     = COORD_ZERO;
          y_next_s     = COORD_ZERO;
          node_next_s  = NODE_ZERO;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_READ: state_next_s = S_WAIT;
      S_WAIT: begin
        state_next_s = S_WRITE;
        dir_next_s   = 4'd0;
      end
      S_WRITE: begin
        if (wr_en && wr_ready) begin
          if (dir_r == 4'd8) begin
            dir_next_s = 4'd0;
            if ((x_r == X_LAST) && (y_r == Y_LAST)) begin
              state_next_s = S_DONE;
              x_next_s     = COORD_ZERO;
              y_next_s     = COORD_ZERO;
              node_next_s  = NODE_ZERO;
            end else begin
              state_next_s = S_READ;
              node_next_s  = node_r + NODE_ONE;
              if (x_r == X_LAST) begin
                x_next_s = COORD_ZERO;
                y_next_s = y_r + COORD_ONE;
              end else begin
                x_next_s = x_r + COORD_ONE;
              end
            end
          end else begin
            dir_next_s = dir_r + 4'd1;
          end
        end else begin
          state_next_s = S_WRITE;
        end
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase

    busy_next_s    = (state_next_s == S_READ) || (state_next_s == S_WAIT) || (state_next_s == S_WRITE);
    done_next_s    = (state_next_s == S_DONE);
    rd_en_next_s   = (state_next_s == S_READ);
    rd_addr_next_s = (state_next_s == S_READ) ? node_next_s : NODE_ZERO;
    wr_en_next_s   = (state_next_s == S_WRITE);
    // Entering WRITE, the buffers are only being loaded on this edge, so dir 0 comes straight off the buses.
    if (state_next_s == S_WRITE) begin
      wr_dir_next_s = dir_next_s;
      if (state_r == S_WAIT) begin
        wr_addr_next_s = addr_slice_s[0];
        wr_data_next_s = data_slice_s[0];
      end else begin
        wr_addr_next_s = addr_buf_r[dir_next_s];
        wr_data_next_s = data_buf_r[dir_next_s];
      end
    end else begin
      wr_dir_next_s  = 4'd0;
      wr_addr_next_s = NODE_ZERO;
      wr_data_next_s = DATA_ZERO;
    end
  end

  // State, coordinates and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      x_r     <= COORD_ZERO;
      y_r     <= COORD_ZERO;
      node_r  <= NODE_ZERO;
      dir_r   <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= NODE_ZERO;
      wr_en   <= 1'b0;
      wr_dir  <= 4'd0;
      wr_addr <= NODE_ZERO;
      wr_data <= DATA_ZERO;
    end else begin
      state_r <= state_next_s;
      x_r     <= x_next_s;
      y_r     <= y_next_s;
      node_r  <= node_next_s;
      dir_r   <= dir_next_s;
      busy    <= busy_next_s;
      done    <= done_next_s;
      rd_en   <= rd_en_next_s;
      rd_addr <= rd_addr_next_s;
      wr_en   <= wr_en_next_s;
      wr_dir  <= wr_dir_next_s;
      wr_addr <= wr_addr_next_s;
      wr_data <= wr_data_next_s;
    end
  end

  // Node snapshot taken at the end of WAIT; later movement on the input buses cannot disturb pending writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        data_buf_r[i] <= DATA_ZERO;
        addr_buf_r[i] <= NODE_ZERO;
      end
    end else if (state_r == S_WAIT) begin
      for (int i = 0; i < 9; i++) begin
        data_buf_r[i] <= data_slice_s[i];
        addr_buf_r[i] <= addr_slice_s[i];
      end
    end else begin
      for (int i = 0; i < 9; i++) begin
        data_buf_r[i] <= data_buf_r[i];
        addr_buf_r[i] <= addr_buf_r[i];
      end
    end
  end

  assign x = x_r;
  assign y = y_r;

endmodule

// File: tb/tb_stream_sweep_controller.sv
// Scoreboard bench: a 4x4 instance for data movement/backpressure/spurious starts and a 16x16
// instance for raster order, full-sweep latency and mid-sweep reset recovery.
`timescale 1ns/1ps
module tb_stream_sweep_controller;
  localparam int GX = 4, GY = 4, AW = 5, NAW = 4, DW = 16;
  localparam int BAW = 9, BNAW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start4, start16;
  logic busy4, done4, rd_en4, wr_en4, wr_ready4;
  logic signed [AW-1:0] x4, y4;
  logic [9*AW-1:0] wa4;
  logic [NAW-1:0] rd_addr4, wr_addr4;
  logic [9*DW-1:0] rd_data4;
  logic [3:0] wr_dir4;
  logic [DW-1:0] wr_data4;

  logic busy16, done16, rd_en16, wr_en16, wr_ready16;
  logic signed [BAW-1:0] x16, y16;
  logic [9*BAW-1:0] wa16;
  logic [BNAW-1:0] rd_addr16, wr_addr16;
  logic [9*DW-1:0] rd_data16;
  logic [3:0] wr_dir16;
  logic [DW-1:0] wr_data16;

  assign wa16       = '0;
  assign rd_data16  = '0;
  assign wr_ready16 = 1'b1;

  stream_sweep_controller #(.GRID_X(GX), .GRID_Y(GY), .DATA_WIDTH(DW)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4), .x(x4), .y(y4),
    .write_addresses(wa4), .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .wr_en(wr_en4), .wr_ready(wr_ready4), .wr_dir(wr_dir4), .wr_addr(wr_addr4), .wr_data(wr_data4));

  stream_sweep_controller #(.GRID_X(16), .GRID_Y(16), .DATA_WIDTH(DW)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .busy(busy16), .done(done16), .x(x16), .y(y16),
    .write_addresses(wa16), .rd_en(rd_en16), .rd_addr(rd_addr16), .rd_data(rd_data16),
    .wr_en(wr_en16), .wr_ready(wr_ready16), .wr_dir(wr_dir16), .wr_addr(wr_addr16), .wr_data(wr_data16));

  int passed = 0, total = 0;
  int cyc = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: condition not met", name);
  endtask

  // Golden periodic D2Q9 neighbour for the 4x4 lattice (0 rest, 1 E, 2 N, 3 W, 4 S, 5 NE, 6 NW, 7 SW, 8 SE).
  function automatic int nbr4(input int n, input int d);
    int dx, dy;
    case (d)
      1: begin dx = 1;  dy = 0;  end
      2: begin dx = 0;  dy = 1;  end
      3: begin dx = -1; dy = 0;  end
      4: begin dx = 0;  dy = -1; end
      5: begin dx = 1;  dy = 1;  end
      6: begin dx = -1; dy = 1;  end
      7: begin dx = -1; dy = -1; end
      8: begin dx = 1;  dy = -1; end
      default: begin dx = 0; dy = 0; end
    endcase
    return (((n / GX) + dy + GY) % GY) * GX + (((n % GX) + dx + GX) % GX);
  endfunction

  // streaming_unit model; corrupted while writing so only latched addresses can be correct.
  always_comb begin
    wa4 = '0;
    for (int i = 0; i < 9; i++)
      wa4[i*AW +: AW] = AW'(nbr4(int'(y4) * GX + int'(x4), i)) ^ (wr_en4 ? {AW{1'b1}} : {AW{1'b0}});
  end

  // Source lattice: f_i[n] = 16*n + i, valid only the cycle after rd_en.
  always @(posedge clk) begin
    for (int i = 0; i < 9; i++)
      rd_data4[i*DW +: DW] <= rd_en4 ? DW'(16 * int'(rd_addr4) + i) : {DW{1'b1}};
  end

  always @(posedge clk) cyc <= cyc + 1;

  bit bp_mode = 1'b0;
  int rdy_cnt = 0;
  always @(posedge clk) begin
    #1;
    wr_ready4 = bp_mode ? (rdy_cnt % 3 == 0) : 1'b1;
    rdy_cnt++;
  end
  initial wr_ready4 = 1'b1;

  typedef struct packed { logic [3:0] dir; logic [NAW-1:0] addr; logic [DW-1:0] data; } wr_t;
  wr_t exp_q[$];
  int  rd_q16[$];
  logic [DW-1:0] dmem [144];
  logic [DW-1:0] snap [144];
  int nwrites4 = 0, stalls4 = 0, w_idx4 = 0, anchor_addr = -1;
  int done_cnt4 = 0, done_cyc4 = 0, first_busy4 = 0;
  int done_cnt16 = 0, done_cyc16 = 0, first_busy16 = 0;
  bit busy4_q = 1'b0, busy16_q = 1'b0, stall_prev = 1'b0;
  logic [3:0] pdir; logic [NAW-1:0] paddr; logic [DW-1:0] pdata;

  // Write monitor for the 4x4 instance.
  always @(negedge clk) begin
    if (stall_prev) begin
      check("stall_wr_en", wr_en4, 1);
      check("stall_wr_dir", wr_dir4, pdir);
      check("stall_wr_addr", wr_addr4, paddr);
      check("stall_wr_data", wr_data4, pdata);
    end
    stall_prev = wr_en4 && !wr_ready4;
    if (stall_prev) stalls4++;
    pdir = wr_dir4; paddr = wr_addr4; pdata = wr_data4;
    if (wr_en4 && wr_ready4) begin
      wr_t e;
      if (exp_q.size() == 0) fail_now("unexpected_write");
      else begin
        e = exp_q.pop_front();
        check("wr_dir", wr_dir4, e.dir);
        check("wr_addr", wr_addr4, e.addr);
        check("wr_data", wr_data4, e.data);
      end
      if (w_idx4 == 3) anchor_addr = int'(wr_addr4);
      w_idx4++;
      nwrites4++;
      dmem[int'(wr_addr4) * 9 + int'(wr_dir4)] = wr_data4;
    end
    if (busy4 && !busy4_q) first_busy4 = cyc;
    busy4_q = busy4;
    if (done4) begin done_cnt4++; done_cyc4 = cyc; end
  end

  // Read-order monitor for the 16x16 instance.
  always @(negedge clk) begin
    if (rd_en16) begin
      int e;
      if (rd_q16.size() == 0) fail_now("unexpected_read16");
      else begin
        e = rd_q16.pop_front();
        check("rd_addr16", rd_addr16, e);
        check("x16", x16, e % 16);
        check("y16", y16, e / 16);
      end
    end
    if (busy16 && !busy16_q) first_busy16 = cyc;
    busy16_q = busy16;
    if (done16) begin done_cnt16++; done_cyc16 = cyc; end
  end

  task automatic wait_done4(input int base);
    bit ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk); #1;
      if (done_cnt4 != base) ok = 1'b1;
    end
    if (!ok) fail_now("timeout_done4");
  endtask

  task automatic wait_done16(input int base);
    bit ok = 1'b0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      @(negedge clk); #1;
      if (done_cnt16 != base) ok = 1'b1;
    end
    if (!ok) fail_now("timeout_done16");
  endtask

  task automatic run4(input bit bp, input bit spurious);
    int base, quiet, mism;
    for (int k = 0; k < 144; k++) dmem[k] = {DW{1'b1}};
    for (int n = 0; n < 16; n++)
      for (int i = 0; i < 9; i++)
        exp_q.push_back('{dir: 4'(i), addr: NAW'(nbr4(n, i)), data: DW'(16 * n + i)});
    nwrites4 = 0; w_idx4 = 0; anchor_addr = -1; stalls4 = 0;
    bp_mode = bp;
    base = done_cnt4;
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    if (spurious) begin
      repeat (40) @(posedge clk);
      #1 start4 = 1'b1;
      @(posedge clk); #1 start4 = 1'b0;
    end
    wait_done4(base);
    start4 = 1'b1;                     // coincident with done: must be ignored
    @(posedge clk); #1 start4 = 1'b0;
    quiet = 0;
    repeat (20) begin @(negedge clk); if (busy4 || rd_en4 || wr_en4) quiet++; end
    bp_mode = 1'b0;
    check("post_done_quiet", quiet, 0);
    check("done_count", done_cnt4 - base, 1);
    check("write_count", nwrites4, 144);
    check("exp_q_drained", exp_q.size(), 0);
    check("node0_dir3_addr", anchor_addr, 3);
    if (!bp) check("latency_4x4", done_cyc4 - first_busy4, 176);
    else check("stalls_seen", stalls4 > 0, 1);
    mism = 0;
    for (int n = 0; n < 16; n++)
      for (int i = 0; i < 9; i++)
        if (dmem[nbr4(n, i) * 9 + i] !== DW'(16 * n + i)) mism++;
    check("dest_mem_golden", mism, 0);
  endtask

  initial begin
    int mism, base, quiet;
    bit found;
    rst_n = 1'b0; start4 = 1'b0; start16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl4", {busy4, done4, rd_en4, wr_en4}, 0);
    check("rst_xy4", {x4, y4}, 0);
    check("rst_ctrl16", {busy16, done16, rd_en16, wr_en16}, 0);
    rst_n = 1'b1;
    quiet = 0;
    repeat (20) begin @(negedge clk); if (busy4 || rd_en4 || wr_en4 || done4) quiet++; end
    check("idle_no_start", quiet, 0);

    run4(1'b0, 1'b1);
    for (int k = 0; k < 144; k++) snap[k] = dmem[k];
    run4(1'b1, 1'b0);
    mism = 0;
    for (int k = 0; k < 144; k++) if (dmem[k] !== snap[k]) mism++;
    check("dest_mem_vs_nostall", mism, 0);

    // 16x16: abort at node 37 dir 4, then a clean full sweep.
    for (int n = 0; n < 256; n++) rd_q16.push_back(n);
    @(posedge clk); #1 start16 = 1'b1;
    @(posedge clk); #1 start16 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk); #1;
      if (wr_en16 && wr_dir16 == 4'd4 && x16 == 9'sd5 && y16 == 9'sd2) found = 1'b1;
    end
    if (!found) fail_now("reach_node37_dir4");
    #2 rst_n = 1'b0;
    #1;
    check("abort_ctrl16", {busy16, done16, rd_en16, wr_en16}, 0);
    check("abort_xy16", {x16, y16}, 0);
    check("abort_wr16", {wr_dir16, wr_addr16, wr_data16}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd_q16.delete();
    base = done_cnt16;
    quiet = 0;
    repeat (30) begin @(negedge clk); if (busy16 || rd_en16 || wr_en16) quiet++; end
    check("abort_no_done", done_cnt16 - base, 0);
    check("abort_stays_idle", quiet, 0);

    for (int n = 0; n < 256; n++) rd_q16.push_back(n);
    @(posedge clk); #1 start16 = 1'b1;
    @(posedge clk); #1 start16 = 1'b0;
    wait_done16(base);
    check("done_count16", done_cnt16 - base, 1);
    check("latency_16x16", done_cyc16 - first_busy16, 2816);
    check("raster_q_drained", rd_q16.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
